apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Upstream APB requester for the peripheral bus: drives psel/penable/pwrite/paddr/pwdata into APB slaves such as the counter/timer peripheral, and consumes pready/prdata/pslverr.
- Converts a simple valid/ready command stream from the control logic into single APB transfers.
- Returns one response per command, with slave-error and timeout reporting.
- Only one transfer is outstanding at any time.

Parameters:
ADDR_WIDTH, 2, width of cmd_addr/paddr
DATA_WIDTH, 8, width of write/read data
TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target register address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at posedge
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  1  slave error or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. Outputs: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout counter=0.
- Reset mid-transfer drops the command immediately; no response is ever produced for it. cmd_ready=1 in the first cycle after reset release.
- States: IDLE, SETUP, ACCESS, RESP.
- psel/penable are decoded from the state register only: SETUP gives 1/0, ACCESS gives 1/1, all other states give 0/0.
- IDLE:
  - cmd_ready=1 (cmd_ready is 0 in every other state).
  - On the accept handshake, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, then go to SETUP.
- SETUP: exactly one cycle, then ACCESS. Clear the timeout counter.
- ACCESS:
  - Sample pready each cycle.
  - pready=1: capture rsp_rdata=prdata for reads, 0 for writes; rsp_err=pslverr; rsp_timeout=0; go to RESP.
  - pready=0: counter++. If TIMEOUT_CYCLES!=0 and this is the TIMEOUT_CYCLES-th ACCESS cycle, go to RESP with rsp_rdata=0, rsp_err=1, rsp_timeout=1.
  - pready on the final allowed cycle wins over the timeout.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1, then go to IDLE.
  - psel=0 throughout RESP, so there is at least one idle bus cycle between transfers (slaves use psel/penable low to return to idle).
- paddr/pwdata/pwrite stay stable from SETUP until the next accept. They are not cleared between transfers.
- pslverr and prdata are ignored outside ACCESS with pready=1.
- Minimum latency (accept at cycle 0, pready in the first ACCESS cycle):
  - SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
  - Next accept no earlier than cycle 4 when rsp_ready=1 at cycle 3.
- Each wait state adds one cycle.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1), saturating. Minimum width 1.

Test Plan:
- Write path, pready=1 in the first ACCESS cycle:
  - Stimulus: write addr=1, wdata=0x05.
  - Response: cycle1 psel=1/penable=0; cycle2 psel=1/penable=1 with pwrite=1, paddr=1, pwdata=0x05; cycle3 rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Read with wait states: read addr=2, pready low for 2 ACCESS cycles, then pready=1 with prdata=0x2A -> rsp_valid at cycle 5, rsp_rdata=0x2A, rsp_err=0, paddr stable throughout.
- Slave error: write addr=2, slave returns pready=1 with pslverr=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: pready never asserted, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Variant with pready on the 16th cycle -> normal response.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles with cmd_valid held high.
  - Response: cmd_ready=0, psel=0, rsp_* unchanged. After rsp_ready=1, IDLE for one cycle, the next command is accepted and its SETUP follows.
- Reset in ACCESS: drive reset=0 mid-cycle -> psel, penable and rsp_valid go to 0 without waiting for a clock edge. After release: cmd_ready=1, no stale response.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB requester: turns a valid/ready command stream into single APB transfers
// and returns one response per command, with slave-error and timeout reporting.
`timescale 1ns/1ps
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;

  // Transfer sequencer: latches the command, counts ACCESS wait cycles, captures the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pwrite      <= 1'b0;
      paddr       <= {ADDR_WIDTH{1'b0}};
      pwdata      <= {DATA_WIDTH{1'b0}};
      rsp_rdata   <= {DATA_WIDTH{1'b0}};
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            state  <= SETUP;
          end else begin
            state  <= IDLE;
          end
        end
        SETUP: begin
          wait_cnt <= {CNT_WIDTH{1'b0}};
          state    <= ACCESS;
        end
        ACCESS: begin
          // pready on the last allowed cycle is checked first, so it beats the timeout
          if (pready) begin
            rsp_rdata   <= pwrite ? {DATA_WIDTH{1'b0}} : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else begin
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + CNT_WIDTH'(1);
            end else begin
              wait_cnt <= wait_cnt;
            end
            if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
              rsp_rdata   <= {DATA_WIDTH{1'b0}};
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              state       <= RESP;
            end else begin
              state       <= ACCESS;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and bus strobes decode straight from the state register, so reset clears them at once.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: fixed vector table, randomized commands against a
// transaction-level model, and an asynchronous reset during ACCESS.
`timescale 1ns/1ps
module tb_apb_cmd_master;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            acc;
  } exp_t;

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] rd;
    logic          se;
    int            hold;
    exp_t          e;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A slave that holds pready low for 'waits' ACCESS cycles; the timeout wins if it never answers in time.
  function automatic exp_t predict(input logic w, input int waits, input logic [DW-1:0] rd,
                                   input logic se);
    exp_t e;
    if (TO != 0 && waits >= TO) begin
      e.rdata = '0; e.err = 1'b1; e.to = 1'b1; e.acc = TO;
    end else begin
      e.rdata = w ? '0 : rd; e.err = se; e.to = 1'b0; e.acc = waits + 1;
    end
    return e;
  endfunction

  // Called and returns at a negedge in IDLE; inputs are driven at negedges, outputs read there too.
  task automatic run_cmd(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int waits, input logic [DW-1:0] rd,
                         input logic se, input int hold, input exp_t e);
    int n;
    int acc;
    logic [DW-1:0] r_rdata;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); n++;
    end
    check({tag, " accept"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, " setup strobes"}, 32'({psel, penable}), 32'b10);
    check({tag, " setup bus"}, 32'({pwrite, paddr, pwdata}), 32'({w, a, d}));
    acc = 0; n = 0; pready = 1'b0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (psel && penable) begin
        acc++;
        check({tag, " access bus"}, 32'({pwrite, paddr, pwdata}), 32'({w, a, d}));
        pready  = (acc == waits + 1);
        prdata  = pready ? rd : 8'($urandom);
        pslverr = pready ? se : 1'($urandom);
      end else begin
        pready = 1'b0; prdata = 8'($urandom); pslverr = 1'($urandom);
        if (rsp_valid) break;
      end
    end
    check({tag, " access cycles"}, 32'(acc), 32'(e.acc));
    check({tag, " rsp latency"}, 32'(n), 32'(e.acc + 1));
    check({tag, " rsp strobes"}, 32'({rsp_valid, psel, penable, cmd_ready}), 32'b1000);
    check({tag, " rsp fields"}, 32'({rsp_rdata, rsp_err, rsp_timeout}), 32'({e.rdata, e.err, e.to}));
    r_rdata = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 2'($urandom); cmd_wdata = 8'($urandom);
      @(negedge clk);
      check({tag, " hold strobes"}, 32'({rsp_valid, psel, cmd_ready}), 32'b100);
      check({tag, " hold fields"}, 32'({rsp_rdata, rsp_err, rsp_timeout}),
            32'({r_rdata, e.err, e.to}));
      check({tag, " hold bus"}, 32'({pwrite, paddr, pwdata}), 32'({w, a, d}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " back to idle"}, 32'({rsp_valid, cmd_ready, psel}), 32'b010);
  endtask

  initial begin
    exp_t e;
    int n;
    logic w;
    int waits;
    logic [DW-1:0] rd;

    vecs[0] = '{1'b1, 2'd1, 8'h05,  0, 8'h77, 1'b0,  0, '{8'h00, 1'b0, 1'b0,  1}};
    vecs[1] = '{1'b0, 2'd2, 8'h00,  2, 8'h2A, 1'b0,  0, '{8'h2A, 1'b0, 1'b0,  3}};
    vecs[2] = '{1'b1, 2'd2, 8'h33,  0, 8'h44, 1'b1,  1, '{8'h00, 1'b1, 1'b0,  1}};
    vecs[3] = '{1'b0, 2'd3, 8'h00, 20, 8'hFF, 1'b0,  0, '{8'h00, 1'b1, 1'b1, 16}};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 15, 8'h5A, 1'b0,  0, '{8'h5A, 1'b0, 1'b0, 16}};
    vecs[5] = '{1'b1, 2'd1, 8'hC3,  1, 8'h11, 1'b0, 10, '{8'h00, 1'b0, 1'b0,  2}};
    vecs[6] = '{1'b0, 2'd1, 8'h00,  0, 8'h81, 1'b1,  2, '{8'h81, 1'b1, 1'b0,  1}};

    repeat (3) @(negedge clk);
    check("reset outputs", 32'({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata,
                                rsp_err, rsp_timeout}), 32'd0);
    reset = 1'b1;
    #1;
    check("ready after reset", 32'({cmd_ready, rsp_valid}), 32'b10);

    for (int i = 0; i < $size(vecs); i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
              vecs[i].rd, vecs[i].se, vecs[i].hold, vecs[i].e);
    end

    for (int i = 0; i < 40; i++) begin
      w     = 1'($urandom);
      waits = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(14, 20));
      rd    = 8'($urandom);
      e     = predict(w, waits, rd, i % 4 == 1);
      run_cmd($sformatf("rnd%0d", i), w, 2'($urandom), 8'($urandom), waits, rd, i % 4 == 1,
              int'($urandom_range(0, 3)), e);
    end

    // Asynchronous reset while the slave is stalling in ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd3; cmd_wdata = 8'hA5; pready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst access strobes", 32'({psel, penable}), 32'b11);
    #2 reset = 1'b0;
    #1;
    check("rst async drop", 32'({psel, penable, rsp_valid}), 32'b000);
    @(negedge clk);
    check("rst mid outputs", 32'({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata,
                                  rsp_err, rsp_timeout}), 32'd0);
    reset = 1'b1;
    #1;
    check("rst release ready", 32'({cmd_ready, rsp_valid}), 32'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst no stale rsp", 32'({rsp_valid, psel, cmd_ready}), 32'b001);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
